// File: rtl/uart_rx_core_if.sv
// Word-delivery channel of the UART receiver: held word, error flags,
// overrun pulse and the consumer's ready.
interface uart_rx_core_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;

  modport master (
    output data, valid, frame_err, parity_err, overrun,
    input  ready
  );

  modport slave (
    input  data, valid, frame_err, parity_err, overrun,
    output ready
  );
endinterface

// File: rtl/uart_rx_core.sv
// UART receiver: two-flop synchronised rx, mid-bit sampling with a fixed
// divider, configurable data/parity/stop, valid/ready holding register.
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            rx_i,
  output logic            busy_o,
  uart_rx_core_if.master  rx_if
);

  localparam int              CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [1:0]      STOP_LAST = 2'(STOP_BITS - 1);
  localparam bit              HAS_PAR   = (PARITY != 0);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_e;

  // Odd mode wants an odd total of ones over data plus parity, even mode an even total.
  function automatic logic parity_bad(input logic [DATA_BITS-1:0] d, input logic p);
    logic ones_odd;
    ones_odd = (^d) ^ p;
    if (PARITY == 1) begin
      parity_bad = ~ones_odd;
    end else if (PARITY == 2) begin
      parity_bad = ones_odd;
    end else begin
      parity_bad = 1'b0;
    end
  endfunction

  logic                 sync1_q, sync2_q;
  state_e               state_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 tick;
  logic [3:0]           bit_q;
  logic [1:0]           stop_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 perr_q, ferr_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, frame_err_q, parity_err_q, overrun_q, busy_q;

  // Two-flop synchroniser for the asynchronous line; idles high.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
    end
  end

  // Sample point: half a bit into the start bit, then every full bit.
  always_comb begin
    tick  = 1'b0;
    cnt_d = cnt_q;
    case (state_q)
      S_IDLE:  tick = 1'b0;
      S_START: tick = (cnt_q == HALF_LAST);
      default: tick = (cnt_q == BIT_LAST);
    endcase
    if (state_q == S_IDLE || tick) begin
      cnt_d = {CW{1'b0}};
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Frame FSM plus the holding register it feeds.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= {CW{1'b0}};
      bit_q        <= 4'd0;
      stop_q       <= 2'd0;
      shift_q      <= {DATA_BITS{1'b0}};
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      data_q       <= {DATA_BITS{1'b0}};
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      overrun_q <= 1'b0;
      if (valid_q && rx_if.ready) begin
        valid_q      <= 1'b0;
        frame_err_q  <= 1'b0;
        parity_err_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (!sync2_q) begin
            state_q <= S_START;
            busy_q  <= 1'b1;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
          end
        end
        S_START: begin
          if (tick) begin
            if (sync2_q) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_DATA;
              bit_q   <= 4'd0;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            shift_q <= {sync2_q, shift_q[DATA_BITS-1:1]};
            if (bit_q == DATA_LAST) begin
              state_q <= HAS_PAR ? S_PAR : S_STOP;
              stop_q  <= 2'd0;
            end else begin
              bit_q <= bit_q + 4'd1;
            end
          end
        end
        S_PAR: begin
          if (tick) begin
            perr_q  <= parity_bad(shift_q, sync2_q);
            state_q <= S_STOP;
          end
        end
        S_STOP: begin
          if (tick) begin
            if (!sync2_q) begin
              ferr_q <= 1'b1;
            end
            if (stop_q == STOP_LAST) begin
              // Leave mid-stop-bit so a following start edge is not missed.
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              if (!valid_q || rx_if.ready) begin
                data_q       <= shift_q;
                frame_err_q  <= ferr_q | ~sync2_q;
                parity_err_q <= perr_q;
                valid_q      <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              stop_q <= stop_q + 2'd1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_if.data       = data_q;
  assign rx_if.valid      = valid_q;
  assign rx_if.frame_err  = frame_err_q;
  assign rx_if.parity_err = parity_err_q;
  assign rx_if.overrun    = overrun_q;
  assign busy_o           = busy_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: directed frames plus randomized frames scored
// against a frame-level reference model, on a default and a parity/2-stop DUT.
module tb_uart_rx_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, rx_a, rx_b, busy_a, busy_b;

  uart_rx_core_if #(.DATA_BITS(8)) ifa ();
  uart_rx_core_if #(.DATA_BITS(7)) ifb ();

  uart_rx_core #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk_i(clk), .reset_i(reset), .rx_i(rx_a), .busy_o(busy_a), .rx_if(ifa.master));

  uart_rx_core #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut_b (
    .clk_i(clk), .reset_i(reset), .rx_i(rx_b), .busy_o(busy_b), .rx_if(ifb.master));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Delivered words {frame_err, parity_err, 6'b0/7'b0, data} and model expectations.
  logic [15:0] qa[$], qb[$], ea[$], eb[$];

  always @(negedge clk) begin
    if (reset === 1'b0 && ifa.valid && ifa.ready) qa.push_back({ifa.frame_err, ifa.parity_err, 6'd0, ifa.data});
    if (reset === 1'b0 && ifb.valid && ifb.ready) qb.push_back({ifb.frame_err, ifb.parity_err, 7'd0, ifb.data});
  end

  // Reference model: line bit sequences (LSB first) and expected flags.
  function automatic logic [15:0] frame_a(input logic [7:0] d, input logic stop);
    return {6'd0, stop, d, 1'b0};
  endfunction

  function automatic logic [15:0] frame_b(input logic [6:0] d, input logic p, input logic s1, input logic s2);
    return {5'd0, s2, s1, p, d, 1'b0};
  endfunction

  function automatic logic [15:0] expect_a(input logic [7:0] d, input logic stop);
    return {~stop, 1'b0, 6'd0, d};
  endfunction

  function automatic logic [15:0] expect_b(input logic [6:0] d, input logic p, input logic s1, input logic s2);
    logic pe;
    pe = ((($countones(d) + int'(p)) % 2) != 0);
    return {~(s1 & s2), pe, 7'd0, d};
  endfunction

  int first_valid, ov_cnt, ov_cyc;

  // Drives one frame, 16 cycles per bit; cycle 0 is the edge where s1 first sees the start bit.
  task automatic send(input int sel, input logic [15:0] fr, input int nb);
    logic was_v, v, ov;
    first_valid = -1;
    ov_cnt      = 0;
    ov_cyc      = -1;
    was_v = (sel != 0) ? ifb.valid : ifa.valid;
    for (int b = 0; b < nb; b++) begin
      if (sel == 0) rx_a = fr[b]; else rx_b = fr[b];
      for (int c = 0; c < 16; c++) begin
        @(posedge clk); #1;
        v  = (sel != 0) ? ifb.valid : ifa.valid;
        ov = (sel != 0) ? ifb.overrun : ifa.overrun;
        if (!was_v && v && first_valid < 0) first_valid = b * 16 + c;
        was_v = v;
        if (ov) begin
          ov_cnt++;
          ov_cyc = b * 16 + c;
        end
      end
    end
    if (sel == 0) rx_a = 1'b1; else rx_b = 1'b1;
  endtask

  task automatic consume(input int sel);
    if (sel == 0) ifa.ready = 1'b1; else ifb.ready = 1'b1;
    @(posedge clk); #1;
    if (sel == 0) ifa.ready = 1'b0; else ifb.ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int  busy_seen, v_seen;
    logic [7:0] d8;
    logic [6:0] d7;
    logic s1, s2, p;
    reset = 1'b1; rx_a = 1'b1; rx_b = 1'b1; ifa.ready = 1'b0; ifb.ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_eq("reset_a", {ifa.data, ifa.valid, ifa.frame_err, ifa.parity_err, ifa.overrun, busy_a}, 32'd0);
    check_eq("reset_b", {ifb.data, ifb.valid, ifb.frame_err, ifb.parity_err, ifb.overrun, busy_b}, 32'd0);
    idle(4);

    // Basic receive and latency, then a one-cycle consume.
    send(0, frame_a(8'hA5, 1'b1), 10);
    check_eq("a5_latency", first_valid, 32'd154);
    check_eq("a5_word", {ifa.frame_err, ifa.parity_err, 6'd0, ifa.data}, expect_a(8'hA5, 1'b1));
    consume(0);
    check_eq("a5_consumed", ifa.valid, 32'd0);

    // Overrun: unconsumed A5 stays, 3C is dropped.
    send(0, frame_a(8'hA5, 1'b1), 10);
    send(0, frame_a(8'h3C, 1'b1), 10);
    check_eq("ovr_count", ov_cnt, 32'd1);
    check_eq("ovr_cycle", ov_cyc, 32'd154);
    check_eq("ovr_held", {ifa.valid, ifa.data}, {1'b1, 8'hA5});
    consume(0);

    // ready tied high: single frame, then two back-to-back.
    qa.delete();
    ifa.ready = 1'b1;
    send(0, frame_a(8'h3C, 1'b1), 10);
    check_eq("rdy_no_ovr", ov_cnt, 32'd0);
    send(0, frame_a(8'h11, 1'b1), 10);
    send(0, frame_a(8'hEE, 1'b1), 10);
    idle(2);
    check_eq("b2b_count", qa.size(), 32'd3);
    if (qa.size() == 3) begin
      check_eq("b2b_w0", qa[0], expect_a(8'h3C, 1'b1));
      check_eq("b2b_w1", qa[1], expect_a(8'h11, 1'b1));
      check_eq("b2b_w2", qa[2], expect_a(8'hEE, 1'b1));
    end
    ifa.ready = 1'b0;
    idle(4);

    // Short low glitch is rejected as a false start.
    busy_seen = 0; v_seen = 0;
    rx_a = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (i == 3) rx_a = 1'b1;
      if (busy_a) busy_seen = 1;
      if (ifa.valid) v_seen = 1;
    end
    check_eq("glitch_busy_seen", busy_seen, 32'd1);
    check_eq("glitch_busy_end", busy_a, 32'd0);
    check_eq("glitch_no_valid", v_seen, 32'd0);
    send(0, frame_a(8'h5A, 1'b1), 10);
    check_eq("after_glitch", {first_valid[15:0], ifa.frame_err, ifa.parity_err, 6'd0, ifa.data},
             {16'd154, expect_a(8'h5A, 1'b1)});
    consume(0);

    // Framing error delivered, cleared on consume, absent on a good frame.
    send(0, frame_a(8'h81, 1'b0), 10);
    check_eq("ferr_word", {ifa.valid, ifa.frame_err, ifa.parity_err, 6'd0, ifa.data},
             {1'b1, expect_a(8'h81, 1'b0)});
    consume(0);
    check_eq("ferr_cleared", {ifa.valid, ifa.frame_err}, 32'd0);
    idle(20);
    send(0, frame_a(8'h81, 1'b1), 10);
    check_eq("ferr_good", {ifa.valid, ifa.frame_err, ifa.parity_err, 6'd0, ifa.data},
             {1'b1, expect_a(8'h81, 1'b1)});
    consume(0);

    // Even parity, 7 data bits, 2 stop bits.
    send(1, frame_b(7'h55, 1'b1, 1'b1, 1'b1), 11);
    check_eq("b_latency", first_valid, 32'd170);
    check_eq("b_perr", {ifb.frame_err, ifb.parity_err, 7'd0, ifb.data}, expect_b(7'h55, 1'b1, 1'b1, 1'b1));
    consume(1);
    send(1, frame_b(7'h55, 1'b0, 1'b1, 1'b1), 11);
    check_eq("b_pok", {ifb.frame_err, ifb.parity_err, 7'd0, ifb.data}, expect_b(7'h55, 1'b0, 1'b1, 1'b1));
    consume(1);

    // Reset in the middle of DATA with a word still held.
    send(0, frame_a(8'h96, 1'b1), 10);
    rx_a = 1'b0;
    idle(40);
    check_eq("mid_busy", {busy_a, ifa.valid}, 32'd3);
    reset = 1'b1; rx_a = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_eq("mid_reset", {ifa.data, ifa.valid, ifa.frame_err, ifa.parity_err, ifa.overrun, busy_a}, 32'd0);
    idle(5);
    send(0, frame_a(8'hC3, 1'b1), 10);
    check_eq("post_reset", {first_valid[15:0], ifa.frame_err, ifa.parity_err, 6'd0, ifa.data},
             {16'd154, expect_a(8'hC3, 1'b1)});
    consume(0);
    idle(4);

    // Randomized frames with occasional stop/parity faults, ready held high.
    qa.delete(); ea.delete(); qb.delete(); eb.delete();
    ifa.ready = 1'b1; ifb.ready = 1'b1;
    for (int n = 0; n < 16; n++) begin
      d8 = 8'($urandom);
      s1 = ($urandom_range(0, 3) != 0);
      ea.push_back(expect_a(d8, s1));
      send(0, frame_a(d8, s1), 10);
      check_eq("rnd_a_ovr", ov_cnt, 32'd0);
      idle(s1 ? $urandom_range(0, 3) : 20);
    end
    for (int n = 0; n < 16; n++) begin
      d7 = 7'($urandom);
      p  = 1'($urandom_range(0, 1));
      s1 = ($urandom_range(0, 3) != 0);
      s2 = ($urandom_range(0, 3) != 0);
      eb.push_back(expect_b(d7, p, s1, s2));
      send(1, frame_b(d7, p, s1, s2), 11);
      check_eq("rnd_b_ovr", ov_cnt, 32'd0);
      idle((s1 && s2) ? $urandom_range(0, 3) : 20);
    end
    idle(4);
    check_eq("rnd_a_count", qa.size(), ea.size());
    check_eq("rnd_b_count", qb.size(), eb.size());
    for (int i = 0; i < ea.size() && i < qa.size(); i++) check_eq("rnd_a_word", qa[i], ea[i]);
    for (int i = 0; i < eb.size() && i < qb.size(); i++) check_eq("rnd_b_word", qb[i], eb[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
